// File: rtl/pwm_audio_out.sv
// pwm_audio_out: plays 8-bit offset-binary samples as 1-bit PWM audio.
// Samples arrive over a valid/ready handshake into a small FIFO. One sample
// is popped at each 256-cycle period boundary and drives the duty cycle for
// the following period.
//
// Ports:
//   clk_in           system clock, rising edge
//   rst_in           synchronous active-low reset
//   sample_in        offset-binary sample (128 = silence)
//   sample_valid_in  sample_in valid this cycle
//   sample_ready_out FIFO has room; push on valid && ready
//   mute_in          force midscale duty while high (FIFO keeps draining)
//   pwm_out          registered PWM bit
//   underrun_out     one-cycle pulse when a period starts with FIFO empty
//   fifo_count_out   current FIFO occupancy
module pwm_audio_out #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [7:0]                    sample_in,
  input  logic                          sample_valid_in,
  output logic                          sample_ready_out,
  input  logic                          mute_in,
  output logic                          pwm_out,
  output logic                          underrun_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out
);

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam logic [DATA_W-1:0] MIDSCALE = DATA_W'(128);

  logic [DATA_W-1:0] pwm_count_q, pwm_count_d;
  logic [DATA_W-1:0] duty_q, duty_d;
  logic              pwm_q, pwm_d;
  logic              underrun_q, underrun_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              push;
  logic              pop;
  logic              boundary;
  logic [DATA_W-1:0] eff;

  // Ready comes straight from the registered occupancy.
  assign sample_ready_out = (count_q < CNT_W'(FIFO_DEPTH));
  assign pwm_out          = pwm_q;
  assign underrun_out     = underrun_q;
  assign fifo_count_out   = count_q;

  // Next-state: PWM counter, FIFO push/pop, duty update and output compare.
  always_comb begin
    pwm_count_d = pwm_count_q + DATA_W'(1);
    duty_d      = duty_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    push     = sample_valid_in && sample_ready_out;
    boundary = (pwm_count_q == {DATA_W{1'b1}});
    // Pop decides on the registered count, so a push on the boundary edge
    // never falls through into the same pop.
    pop      = boundary && (count_q != '0);

    underrun_d = boundary && (count_q == '0);
    eff        = mute_in ? MIDSCALE : duty_q;
    pwm_d      = (pwm_count_q < eff);

    if (push) begin
      mem_d[wr_ptr_q] = sample_in;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      duty_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      pwm_count_q <= '0;
      duty_q      <= MIDSCALE;
      pwm_q       <= 1'b0;
      underrun_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      pwm_count_q <= pwm_count_d;
      duty_q      <= duty_d;
      pwm_q       <= pwm_d;
      underrun_q  <= underrun_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mem_q       <= mem_d;
    end
  end

endmodule

// File: tb/tb_pwm_audio_out.sv
// Testbench for pwm_audio_out: directed stimulus with a period scoreboard.
// Stimulus pushes per-period expectations (high-cycle count, underrun at the
// boundary that ends the period); a negedge monitor measures each period and
// compares against the queue head.
module tb_pwm_audio_out;

  localparam int unsigned DEPTH = 4;

  logic                     clk_in = 1'b0;
  logic                     rst_in;
  logic [7:0]               sample_in;
  logic                     sample_valid_in;
  logic                     sample_ready_out;
  logic                     mute_in;
  logic                     pwm_out;
  logic                     underrun_out;
  logic [$clog2(DEPTH):0]   fifo_count_out;

  pwm_audio_out #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .sample_in        (sample_in),
    .sample_valid_in  (sample_valid_in),
    .sample_ready_out (sample_ready_out),
    .mute_in          (mute_in),
    .pwm_out          (pwm_out),
    .underrun_out     (underrun_out),
    .fifo_count_out   (fifo_count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int high;
    int ur;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;   // edges since reset release
  int   hi_acc = 0;
  int   ur_acc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_period(input int high, input int ur);
    exp_t e;
    e.high = high;
    e.ur   = ur;
    exp_q.push_back(e);
  endtask

  always @(posedge clk_in) begin
    cyc <= rst_in ? cyc + 1 : 0;
  end

  // Period monitor: window for a period is edges 256k+1 .. 256k+256.
  always @(negedge clk_in) begin
    exp_t e;
    if (!rst_in || cyc == 0) begin
      hi_acc = 0;
      ur_acc = 0;
    end else begin
      hi_acc += int'(pwm_out === 1'b1);
      ur_acc += int'(underrun_out === 1'b1);
      if (cyc % 256 == 0) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("period_high",       32'(hi_acc),       32'(e.high));
          check("period_underruns",  32'(ur_acc),       32'(e.ur));
          check("boundary_underrun", 32'(underrun_out), 32'(e.ur));
        end
        hi_acc = 0;
        ur_acc = 0;
      end
    end
  end

  task automatic goto(input int n);
    while (cyc < n) @(negedge clk_in);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [7:0] v, input int max_wait, output int waited);
    sample_in       = v;
    sample_valid_in = 1'b1;
    waited          = 0;
    while (sample_ready_out !== 1'b1 && waited < max_wait) begin
      @(negedge clk_in);
      waited++;
    end
    if (sample_ready_out !== 1'b1) begin
      check("push_ready_timeout", 32'(sample_ready_out), 32'd1);
    end
    @(negedge clk_in);
    sample_valid_in = 1'b0;
  endtask

  task automatic drain(input int limit);
    while (exp_q.size() != 0 && cyc < limit) @(negedge clk_in);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Hold reset 3 cycles with a valid sample offered; release at a negedge.
  task automatic do_reset();
    rst_in          = 1'b0;
    sample_valid_in = 1'b1;
    sample_in       = 8'hAA;
    mute_in         = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk_in);
    check("rst_pwm",      32'(pwm_out),          32'd0);
    check("rst_underrun", 32'(underrun_out),     32'd0);
    check("rst_count",    32'(fifo_count_out),   32'd0);
    check("rst_ready",    32'(sample_ready_out), 32'd1);
    rst_in          = 1'b1;
    sample_valid_in = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    rst_in          = 1'b0;
    sample_valid_in = 1'b0;
    sample_in       = 8'd0;
    mute_in         = 1'b0;
    @(negedge clk_in);

    // Single tone step
    do_reset();
    expect_period(128, 0);
    expect_period(64, 1);
    push(8'd64, 4, w);
    check("tone_count_after_push", 32'(fifo_count_out), 32'd1);
    goto(256);
    check("tone_pwm_c256",   32'(pwm_out),        32'd0);
    check("tone_count_c256", 32'(fifo_count_out), 32'd0);
    goto(257);
    check("tone_pwm_c257", 32'(pwm_out), 32'd1);
    goto(320);
    check("tone_pwm_c320", 32'(pwm_out), 32'd1);
    goto(321);
    check("tone_pwm_c321", 32'(pwm_out), 32'd0);
    drain(600);

    // Backpressure
    do_reset();
    expect_period(128, 0);
    expect_period(10, 0);
    expect_period(20, 0);
    expect_period(30, 0);
    expect_period(40, 0);
    expect_period(50, 1);
    push(8'd10, 4, w);
    push(8'd20, 4, w);
    push(8'd30, 4, w);
    push(8'd40, 4, w);
    check("bp_full_ready", 32'(sample_ready_out), 32'd0);
    check("bp_full_count", 32'(fifo_count_out),   32'd4);
    push(8'd50, 400, w);
    check("bp_accept_cycle", 32'(cyc),            32'd257);
    check("bp_count_after",  32'(fifo_count_out), 32'd4);
    drain(1700);

    // Underrun with held duty
    do_reset();
    expect_period(128, 0);
    expect_period(200, 1);
    expect_period(200, 1);
    expect_period(200, 1);
    push(8'd200, 4, w);
    drain(1200);

    // Extremes and mid-period mute
    do_reset();
    expect_period(128, 0);
    expect_period(0, 0);
    expect_period(255, 0);
    expect_period(118, 0);   // 100 for counts 0..109, then 128 threshold
    expect_period(128, 1);   // 180 queued but muted
    expect_period(180, 1);
    push(8'd0, 4, w);
    push(8'd255, 4, w);
    push(8'd100, 4, w);
    push(8'd180, 4, w);
    goto(878);
    check("mute_pwm_before", 32'(pwm_out), 32'd0);
    mute_in = 1'b1;
    goto(879);
    check("mute_pwm_after", 32'(pwm_out), 32'd1);
    goto(1023);
    check("mute_count_c1023", 32'(fifo_count_out), 32'd1);
    goto(1024);
    check("mute_count_c1024", 32'(fifo_count_out), 32'd0);
    goto(1280);
    mute_in = 1'b0;
    drain(1700);

    // Push on the boundary edge: holding one sample, then empty
    do_reset();
    expect_period(128, 0);
    expect_period(10, 0);
    expect_period(20, 1);
    expect_period(20, 0);
    expect_period(30, 1);
    push(8'd10, 4, w);
    goto(255);
    check("bnd_count_c255", 32'(fifo_count_out), 32'd1);
    push(8'd20, 4, w);
    check("bnd_count_c256", 32'(fifo_count_out), 32'd1);
    goto(767);
    check("bnd_empty_c767", 32'(fifo_count_out), 32'd0);
    push(8'd30, 4, w);
    check("bnd_underrun_c768", 32'(underrun_out),   32'd1);
    check("bnd_count_c768",    32'(fifo_count_out), 32'd1);
    drain(1400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_audio_out.md
# pwm_audio_out

Sample-consuming end of the tone path. Accepts 8-bit offset-binary amplitude samples (0 = −1.0, 128 = 0.0, 255 ≈ +1.0), as produced by the sine generators, through a valid/ready handshake. Buffers them in a small FIFO and plays one sample per PWM period as a single-bit pulse-width-modulated output for the board's audio low-pass filter and amplifier. Sits between the note/sine-generation logic and the audio output pin.

## Interface

Parameters:
- FIFO_DEPTH, 4: sample buffer depth; power of two, 2..16.

Ports:
- clk_in  input  1  system clock; all logic on its rising edge.
- rst_in  input  1  reset; one clock, synchronous, active-low (logic reset while rst_in == 0).
- sample_in  input  8  offset-binary amplitude sample.
- sample_valid_in  input  1  sample_in is valid this cycle.
- sample_ready_out  output  1  FIFO can accept a sample; a push occurs when valid && ready.
- mute_in  input  1  forces midscale (128) output while high; the FIFO keeps draining.
- pwm_out  output  1  registered PWM audio bit.
- underrun_out  output  1  one-cycle pulse when a period starts with the FIFO empty.
- fifo_count_out  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation

- Reset (rst_in == 0 at a clock edge):
  - pwm_count = 0, duty_q = 128, pwm_out = 0, FIFO empty.
  - fifo_count_out = 0, sample_ready_out = 1, underrun_out = 0.
  - Reset mid-period or mid-push discards all buffered samples and the in-flight push.
- PWM counter: 8-bit pwm_count increments every cycle and wraps 255 → 0. Each period is 256 cycles.
- Period boundary: the edge where pwm_count goes from 255 to 0.
  - FIFO non-empty: pop the head into duty_q.
  - FIFO empty: duty_q holds its previous value; underrun_out pulses high for exactly one cycle, coinciding with pwm_count == 0.
- Effective duty: eff = mute_in ? 128 : duty_q, sampled every cycle. Mute therefore takes effect mid-period.
- Output: pwm_out <= (pwm_count < eff).
  - eff = 0 gives an all-low period.
  - eff = 255 gives 255 high cycles and 1 low cycle per period. Full-high is not reachable; this is accepted.
- FIFO: synchronous, first-in first-out, with pointers wrapping modulo FIFO_DEPTH.
  - sample_ready_out = (count < FIFO_DEPTH), driven combinationally from registered count.
  - Push and pop in the same cycle: count unchanged, both take effect.
  - Push into an empty FIFO on a boundary edge: no fall-through. The pop sees the FIFO empty, an underrun is flagged, and the sample is played at the next boundary.
  - Push while full: ready is 0, so no push occurs and the sample is not lost; the source holds it.
- Data is never reordered, duplicated or dropped except by reset.

## Timing

- Push latency: the sample accepted at edge t enters the FIFO at t; fifo_count_out reflects it at t+1 (visible after edge t).
- Playback: a sample popped at boundary edge b (pwm_count becomes 0) drives pwm_out from edge b+1 through edge b+256. pwm_out lags pwm_count by one cycle.
- After reset release, the first period plays midscale. With the FIFO still empty at the first boundary (edge 256 after release), underrun_out pulses.
- sample_ready_out deasserts in the cycle after the push that fills the FIFO. It reasserts in the cycle after the next pop.
- Sustained throughput: one sample per 256 cycles. The producer may burst up to FIFO_DEPTH samples back to back, one per cycle.

## Test plan

- Reset: hold rst_in = 0 for 3 cycles with sample_valid_in = 1.
  - Required: pwm_out = 0, underrun_out = 0, fifo_count_out = 0, sample_ready_out = 1.
  - Required: no sample accepted.
- Single tone step: push 64 after reset release.
  - Required: the first period plays midscale (128 high cycles).
  - Required: underrun_out does not fire at the first boundary.
  - Required: the next period has exactly 64 high cycles, starting one cycle after pwm_count = 0.
- Backpressure: push 5 samples back to back (10, 20, 30, 40, 50) with FIFO_DEPTH = 4.
  - Required: ready drops after the 4th push; 50 is held by the source.
  - Required: after the next boundary, 50 is accepted.
  - Required: periods play 10, 20, 30, 40, 50 high cycles in order.
- Underrun: push 200, then stop.
  - Required: one period of 200 high cycles, then repeated 200-high periods.
  - Required: underrun_out pulses one cycle at each subsequent boundary.
- Extremes and mute: push 0 and then 255.
  - Required: 0 gives 0 high cycles; 255 gives 255 high cycles and 1 low.
  - Assert mute_in mid-period: from the next cycle, pwm_out follows the 128 threshold.
  - Required: the FIFO still pops at the boundary and fifo_count_out decrements.
- Simultaneous boundary push:
  - FIFO holding 1 sample, push on the boundary edge: fifo_count_out stays 1.
  - FIFO empty, push on the boundary edge: underrun_out fires, and the pushed sample plays in the following period.
